// File: rtl/bist_scan_ctrl.sv
// Logic BIST scan controller: an LFSR drives the pattern and a MISR compresses the responses.
// Runs shift/capture over NUM_CHAINS scan chains, then compares the MISR with golden_sig.
module bist_scan_ctrl #(
    parameter int                 NUM_CHAINS = 2,
    parameter int                 CHAIN_LEN  = 4,
    parameter int                 N_PATTERNS = 8,
    parameter int                 LFSR_W     = 8,
    parameter logic [LFSR_W-1:0]  LFSR_POLY  = 8'hB8,
    parameter logic [LFSR_W-1:0]  LFSR_SEED  = 8'h01,
    parameter int                 MISR_W     = 16,
    parameter logic [MISR_W-1:0]  MISR_POLY  = 16'hB400
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bist_start,
    input  logic                  bist_abort,
    input  logic [MISR_W-1:0]     golden_sig,
    input  logic [NUM_CHAINS-1:0] cut_scan_out,
    output logic [NUM_CHAINS-1:0] cut_scan_in,
    output logic                  cut_scan_en,
    output logic                  cut_capture,
    output logic                  busy,
    output logic                  bist_end,
    output logic                  pass_nfail,
    output logic [MISR_W-1:0]     signature
);

    localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int PW = $clog2(N_PATTERNS + 1);

    localparam logic [BW-1:0] LAST_BIT   = BW'(CHAIN_LEN - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(N_PATTERNS);

    // A zero seed would lock the LFSR, so a run reloads 1 instead.
    localparam logic [LFSR_W-1:0] SEED_RUN =
        (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [LFSR_W-1:0] lfsr_q, lfsr_next;
    logic [MISR_W-1:0] misr_q, misr_next, scan_ext;
    logic [BW-1:0]     bit_q;
    logic [PW-1:0]     phase_q;
    logic              start_q, pass_q;

    logic start_rise, last_bit, last_phase;
    logic load, lfsr_adv, misr_adv, cnt_adv, cmp, clr_pass;

    assign start_rise = bist_start & ~start_q;
    assign last_bit   = (bit_q == LAST_BIT);
    assign last_phase = (phase_q == LAST_PHASE);

    // Galois LFSR step and MISR step with the returned scan bits folded in.
    always_comb begin
        lfsr_next = (lfsr_q >> 1) ^ ({LFSR_W{lfsr_q[0]}} & LFSR_POLY);
        scan_ext  = '0;
        scan_ext[NUM_CHAINS-1:0] = cut_scan_out;
        misr_next = (misr_q << 1)
                  ^ ({MISR_W{misr_q[MISR_W-1]}} & MISR_POLY)
                  ^ scan_ext;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, datapath strobes and CUT-facing outputs.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        lfsr_adv    = 1'b0;
        misr_adv    = 1'b0;
        cnt_adv     = 1'b0;
        cmp         = 1'b0;
        clr_pass    = 1'b0;
        cut_scan_in = '0;
        cut_scan_en = 1'b0;
        cut_capture = 1'b0;
        busy        = 1'b0;
        bist_end    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                bist_end = (state_q == S_DONE);
                if (start_rise) begin
                    load     = 1'b1;
                    clr_pass = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy        = 1'b1;
                cut_scan_en = 1'b1;
                cnt_adv     = 1'b1;
                if (!last_phase) begin
                    cut_scan_in = lfsr_q[NUM_CHAINS-1:0];
                    lfsr_adv    = 1'b1;
                end
                if (phase_q != '0) begin
                    misr_adv = 1'b1;
                end
                if (last_bit) begin
                    state_d = last_phase ? S_COMPARE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                busy        = 1'b1;
                cut_capture = 1'b1;
                state_d     = S_SHIFT;
            end
            S_COMPARE: begin
                busy    = 1'b1;
                cmp     = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (busy && bist_abort) begin
            state_d  = S_IDLE;
            lfsr_adv = 1'b0;
            misr_adv = 1'b0;
            cnt_adv  = 1'b0;
            cmp      = 1'b0;
            clr_pass = 1'b1;
        end
    end

    // Pattern generator, signature register, counters and verdict.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q  <= LFSR_SEED;
            misr_q  <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            pass_q  <= 1'b0;
            start_q <= 1'b1;
        end else begin
            start_q <= bist_start;
            if (load) begin
                lfsr_q  <= SEED_RUN;
                misr_q  <= '0;
                bit_q   <= '0;
                phase_q <= '0;
            end else begin
                if (lfsr_adv) begin
                    lfsr_q <= lfsr_next;
                end
                if (misr_adv) begin
                    misr_q <= misr_next;
                end
                if (cnt_adv) begin
                    bit_q <= last_bit ? '0 : bit_q + 1'b1;
                    if (last_bit && !last_phase) begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
            end
            if (clr_pass) begin
                pass_q <= 1'b0;
            end else if (cmp) begin
                pass_q <= (misr_q == golden_sig);
            end
        end
    end

    assign pass_nfail = pass_q;
    assign signature  = misr_q;

endmodule

// File: tb/tb_bist_scan_ctrl.sv
// Bench for bist_scan_ctrl: a CUT of shift-register chains with an XOR capture
// function, and a pattern-level reference model of the expected signature.
module tb_bist_scan_ctrl;

    localparam int NC = 2;
    localparam int L  = 4;
    localparam int NP = 8;
    localparam int LW = 8;
    localparam int MW = 16;
    localparam logic [LW-1:0] LPOLY = 8'hB8;
    localparam logic [LW-1:0] LSEED = 8'h01;
    localparam logic [MW-1:0] MPOLY = 16'hB400;
    localparam int END_EDGE = (NP + 1) * L + NP + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          bist_start = 1'b0;
    logic          bist_abort = 1'b0;
    logic [MW-1:0] golden_sig = '0;
    logic [NC-1:0] cut_scan_out;
    logic [NC-1:0] cut_scan_in;
    logic          cut_scan_en;
    logic          cut_capture;
    logic          busy;
    logic          bist_end;
    logic          pass_nfail;
    logic [MW-1:0] signature;

    int errors = 0;
    int checks = 0;

    logic [L-1:0]  chain [NC];
    logic [L-1:0]  key   [NC];
    bit            stuck = 0;
    logic [LW-1:0] stream [NP*L];

    bist_scan_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .bist_start   (bist_start),
        .bist_abort   (bist_abort),
        .golden_sig   (golden_sig),
        .cut_scan_out (cut_scan_out),
        .cut_scan_in  (cut_scan_in),
        .cut_scan_en  (cut_scan_en),
        .cut_capture  (cut_capture),
        .busy         (busy),
        .bist_end     (bist_end),
        .pass_nfail   (pass_nfail),
        .signature    (signature)
    );

    always #5 clock = ~clock;

    function automatic logic [L-1:0] cap_fn(input logic [L-1:0] a,
                                            input logic [L-1:0] b,
                                            input logic [L-1:0] k,
                                            input bit zero);
        if (zero) return '0;
        return a ^ {b[L-2:0], b[L-1]} ^ k;
    endfunction

    // CUT: each chain shifts towards its MSB, which is the scan output.
    always @(posedge clock) begin
        for (int i = 0; i < NC; i++) begin
            if (cut_scan_en)
                chain[i] <= {chain[i][L-2:0], cut_scan_in[i]};
            else if (cut_capture)
                chain[i] <= cap_fn(chain[i], chain[(i+1)%NC], key[i],
                                   stuck && i == 1);
        end
    end

    always_comb begin
        for (int i = 0; i < NC; i++) cut_scan_out[i] = chain[i][L-1];
    end

    // Pattern values presented on the load cycles, in order.
    task automatic build_stream();
        logic [LW-1:0] lf;
        lf = (LSEED == '0) ? LW'(1) : LSEED;
        for (int t = 0; t < NP*L; t++) begin
            stream[t] = lf;
            lf = (lf >> 1) ^ (lf[0] ? LPOLY : '0);
        end
    endtask

    // Load pattern p, capture it, unload it into the MISR, for every pattern.
    function automatic logic [MW-1:0] model_sig(input bit st);
        logic [L-1:0]  ld [NC];
        logic [L-1:0]  cp [NC];
        logic [MW-1:0] m;
        logic [MW-1:0] v;
        m = '0;
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < NC; i++)
                for (int c = 0; c < L; c++)
                    ld[i][L-1-c] = stream[p*L+c][i];
            for (int i = 0; i < NC; i++)
                cp[i] = cap_fn(ld[i], ld[(i+1)%NC], key[i], st && i == 1);
            for (int c = 0; c < L; c++) begin
                v = '0;
                for (int i = 0; i < NC; i++) v[i] = cp[i][L-1-c];
                m = (m << 1) ^ (m[MW-1] ? MPOLY : '0) ^ v;
            end
        end
        return m;
    endfunction

    task automatic new_keys();
        for (int i = 0; i < NC; i++) key[i] = L'($urandom);
    endtask

    // Starts a run with a fresh rising edge, checks the per-cycle scan
    // sequence and returns the edge at which bist_end rose.
    task automatic do_run(output int end_edge, output int n_cap,
                          output int n_sen);
        int bad;
        int p;
        int c;
        logic          e_sen;
        logic          e_cap;
        logic [NC-1:0] e_in;
        bad = 0;
        n_cap = 0;
        n_sen = 0;
        end_edge = -1;
        bist_start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        bist_start = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1 || bist_end !== 1'b0 || pass_nfail !== 1'b0) begin
            errors++;
            $display("FAIL run_start busy/end/pass=%b%b%b required 100",
                     busy, bist_end, pass_nfail);
        end
        for (int k = 0; k < 100; k++) begin
            if (bist_end === 1'b1) begin
                end_edge = k;
                break;
            end
            p = k / (L + 1);
            c = k % (L + 1);
            e_sen = (c < L);
            e_cap = (c == L) && (p < NP);
            e_in  = '0;
            if (c < L && p < NP) e_in = stream[p*L+c][NC-1:0];
            if (cut_scan_en !== e_sen || cut_capture !== e_cap ||
                cut_scan_in !== e_in || busy !== 1'b1) bad++;
            if (cut_capture === 1'b1 && cut_scan_en === 1'b1) bad++;
            n_cap += int'(cut_capture);
            n_sen += int'(cut_scan_en);
            @(posedge clock);
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL scan_sequence bad_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if ({cut_scan_in, cut_scan_en, cut_capture, busy, bist_end,
             pass_nfail} !== '0 || signature !== '0) begin
            errors++;
            $display("FAIL reset_outputs sig=%h ctl=%b%b%b%b%b in=%b required 0",
                     signature, cut_scan_en, cut_capture, busy, bist_end,
                     pass_nfail, cut_scan_in);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_pass();
        int e;
        int nc;
        int ns;
        logic [MW-1:0] exp;
        new_keys();
        stuck = 0;
        exp = model_sig(0);
        golden_sig = exp;
        do_run(e, nc, ns);
        checks++;
        if (e != END_EDGE || busy !== 1'b0 || pass_nfail !== 1'b1) begin
            errors++;
            $display("FAIL pass_run edge=%0d busy=%b pass=%b required %0d 0 1",
                     e, busy, pass_nfail, END_EDGE);
        end
        checks++;
        if (signature !== exp) begin
            errors++;
            $display("FAIL pass_sig got=%h required %h", signature, exp);
        end
        checks++;
        if (nc != NP || ns != (NP + 1) * L) begin
            errors++;
            $display("FAIL pulse_counts cap=%0d sen=%0d required %0d %0d",
                     nc, ns, NP, (NP + 1) * L);
        end
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (bist_end !== 1'b1 || pass_nfail !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_hold end/pass/busy=%b%b%b required 110",
                     bist_end, pass_nfail, busy);
        end
        bist_start = 1'b0;
    endtask

    task automatic test_golden_flip();
        int e;
        int nc;
        int ns;
        logic [MW-1:0] exp;
        exp = model_sig(0);
        golden_sig = exp ^ 16'h0001;
        do_run(e, nc, ns);
        checks++;
        if (e != END_EDGE || pass_nfail !== 1'b0 || signature !== exp) begin
            errors++;
            $display("FAIL golden_flip edge=%0d pass=%b sig=%h required %0d 0 %h",
                     e, pass_nfail, signature, END_EDGE, exp);
        end
        bist_start = 1'b0;
    endtask

    task automatic test_stuck();
        int e;
        int nc;
        int ns;
        logic [MW-1:0] good;
        logic [MW-1:0] bad_sig;
        new_keys();
        good = model_sig(0);
        bad_sig = model_sig(1);
        golden_sig = good;
        stuck = 1;
        do_run(e, nc, ns);
        stuck = 0;
        checks++;
        if (signature !== bad_sig ||
            pass_nfail !== logic'(bad_sig == good)) begin
            errors++;
            $display("FAIL stuck_at sig=%h pass=%b required %h %b",
                     signature, pass_nfail, bad_sig, bad_sig == good);
        end
        bist_start = 1'b0;
    endtask

    task automatic test_abort();
        int e;
        int nc;
        int ns;
        int stray;
        logic [MW-1:0] exp;
        new_keys();
        exp = model_sig(0);
        golden_sig = exp;
        @(posedge clock);
        @(negedge clock);
        bist_start = 1'b1;
        @(posedge clock);
        repeat (20) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre busy=%b required 1", busy);
        end
        bist_abort = 1'b1;
        @(posedge clock);
        #1;
        bist_abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || bist_end !== 1'b0 || pass_nfail !== 1'b0 ||
            cut_scan_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle busy/end/pass/sen=%b%b%b%b required 0000",
                     busy, bist_end, pass_nfail, cut_scan_en);
        end
        stray = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abort_no_retrigger busy_cycles=%0d required 0", stray);
        end
        do_run(e, nc, ns);
        checks++;
        if (e != END_EDGE || pass_nfail !== 1'b1 || signature !== exp) begin
            errors++;
            $display("FAIL abort_rerun edge=%0d pass=%b sig=%h required %0d 1 %h",
                     e, pass_nfail, signature, END_EDGE, exp);
        end
        bist_start = 1'b0;
    endtask

    task automatic test_reset_mid();
        int e;
        int nc;
        int ns;
        int stray;
        logic [MW-1:0] exp;
        new_keys();
        exp = model_sig(0);
        golden_sig = exp;
        @(posedge clock);
        @(negedge clock);
        bist_start = 1'b1;
        @(posedge clock);
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({cut_scan_in, cut_scan_en, cut_capture, busy, bist_end,
             pass_nfail} !== '0 || signature !== '0) begin
            errors++;
            $display("FAIL reset_mid sig=%h busy=%b sen=%b required 0 0 0",
                     signature, busy, cut_scan_en);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        stray = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (busy !== 1'b0 || cut_scan_en !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_held_start busy_cycles=%0d required 0", stray);
        end
        do_run(e, nc, ns);
        checks++;
        if (e != END_EDGE || pass_nfail !== 1'b1 || signature !== exp) begin
            errors++;
            $display("FAIL reset_rerun edge=%0d pass=%b sig=%h required %0d 1 %h",
                     e, pass_nfail, signature, END_EDGE, exp);
        end
        bist_start = 1'b0;
    endtask

    task automatic test_back_to_back();
        int e;
        int nc;
        int ns;
        bit flip;
        logic [MW-1:0] exp;
        for (int r = 0; r < 3; r++) begin
            new_keys();
            flip = 1'($urandom);
            exp = model_sig(0);
            golden_sig = flip ? exp ^ (MW'(1) << $urandom_range(0, MW - 1))
                              : exp;
            do_run(e, nc, ns);
            checks++;
            if (e != END_EDGE || signature !== exp ||
                pass_nfail !== logic'(!flip)) begin
                errors++;
                $display("FAIL b2b_%0d edge=%0d pass=%b sig=%h required %0d %b %h",
                         r, e, pass_nfail, signature, END_EDGE, !flip, exp);
            end
        end
        bist_start = 1'b0;
    endtask

    initial begin
        build_stream();
        test_reset();
        test_pass();
        test_golden_flip();
        test_stuck();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
